// File: rtl/oh_parity_ctrl.sv
// oh_parity_ctrl: packet parity sequencer. Folds the XOR reduction of each
// beat into a running bit, produces one parity result per packet, can check
// it against an expected bit, and keeps a saturating mismatch count.
module oh_parity_ctrl #(
  parameter int N   = 32,
  parameter int CW  = 16,
  parameter int ODD = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  input  logic          chk_en,
  input  logic          chk_parity,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_parity,
  output logic          out_error,
  output logic [15:0]   out_beats,
  input  logic          err_clr,
  output logic [CW-1:0] err_count
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic ODD_BIT = (ODD != 0);

  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic          chk_q, chk_d;
  logic [15:0]   beats_q, beats_d;
  logic          out_parity_q, out_parity_d;
  logic          out_error_q, out_error_d;
  logic [15:0]   out_beats_q, out_beats_d;
  logic [CW-1:0] err_count_q, err_count_d;

  logic          accept;
  logic          beat_par;
  logic          load;
  logic          fin_acc;
  logic          fin_chk;
  logic [15:0]   fin_beats;
  logic          par_next;
  logic          err_next;

  assign in_ready   = ~reset & (state_q != S_DONE);
  assign out_valid  = (state_q == S_DONE);
  assign out_parity = out_parity_q;
  assign out_error  = out_error_q;
  assign out_beats  = out_beats_q;
  assign err_count  = err_count_q;

  assign accept   = in_valid & in_ready;
  assign beat_par = ^in_data;

  // Next-state, accumulator and result-register computation.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    chk_d        = chk_q;
    beats_d      = beats_q;
    out_parity_d = out_parity_q;
    out_error_d  = out_error_q;
    out_beats_d  = out_beats_q;
    err_count_d  = err_count_q;
    load         = 1'b0;
    fin_acc      = acc_q;
    fin_chk      = chk_q;
    fin_beats    = beats_q;
    par_next     = 1'b0;
    err_next     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          fin_acc   = beat_par;
          fin_chk   = chk_en;
          fin_beats = 16'd1;
          acc_d     = fin_acc;
          chk_d     = fin_chk;
          beats_d   = fin_beats;
          if (in_last) begin
            load    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (accept) begin
          fin_acc   = acc_q ^ beat_par;
          fin_beats = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
          acc_d     = fin_acc;
          beats_d   = fin_beats;
          if (in_last) begin
            load    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      par_next     = fin_acc ^ ODD_BIT;
      err_next     = fin_chk & (par_next != chk_parity);
      out_parity_d = par_next;
      out_error_d  = err_next;
      out_beats_d  = fin_beats;
      if (err_next && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
    end

    if (err_clr) err_count_d = '0;
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= 1'b0;
      chk_q        <= 1'b0;
      beats_q      <= '0;
      out_parity_q <= 1'b0;
      out_error_q  <= 1'b0;
      out_beats_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      chk_q        <= chk_d;
      beats_q      <= beats_d;
      out_parity_q <= out_parity_d;
      out_error_q  <= out_error_d;
      out_beats_q  <= out_beats_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule
